// File: rtl/ascon_perm_sequencer_if.sv
// ---------------------------------------------------------------------------
// ascon_perm_sequencer_if
//
// Bundles the request and result channels of the Ascon permutation
// sequencer.
//
//   start_valid_i / start_ready_o : request channel. state_i and rounds_i are
//                                   sampled on the cycle both are high.
//   done_valid_o  / done_ready_i  : result channel. state_o and error_o are
//                                   qualified by done_valid_o.
//   busy_o                        : high while rounds are being applied.
//   fsm_dbg_o                     : raw sequencer state, for observation only.
//
// Handshake rules for both channels: a transfer happens on a rising clock
// edge where valid and ready are both high. A producer holds valid and its
// payload stable until the transfer. Ready never depends combinationally on
// valid.
//
// The 320-bit state is the five Ascon words x0..x4 with x0 in bits
// [319:256] and x4 in bits [63:0].
//
// Modports: slave = sequencer side, master = requester/consumer side.
// ---------------------------------------------------------------------------
interface ascon_perm_sequencer_if;
    logic         start_valid_i;
    logic         start_ready_o;
    logic [319:0] state_i;
    logic [3:0]   rounds_i;
    logic         done_valid_o;
    logic         done_ready_i;
    logic [319:0] state_o;
    logic         error_o;
    logic         busy_o;
    logic [1:0]   fsm_dbg_o;

    modport slave (
        input  start_valid_i,
        input  state_i,
        input  rounds_i,
        input  done_ready_i,
        output start_ready_o,
        output done_valid_o,
        output state_o,
        output error_o,
        output busy_o,
        output fsm_dbg_o
    );

    modport master (
        output start_valid_i,
        output state_i,
        output rounds_i,
        output done_ready_i,
        input  start_ready_o,
        input  done_valid_o,
        input  state_o,
        input  error_o,
        input  busy_o,
        input  fsm_dbg_o
    );
endinterface

// File: rtl/ascon_perm_sequencer.sv
// ---------------------------------------------------------------------------
// ascon_perm_sequencer
//
// Multi-cycle controller around a combinational slice that applies
// HW_PERMUTATION_N Ascon rounds per clock. A request carries a 320-bit state
// and a round count (12, 8 or 6); the sequencer runs rounds_i/N slice
// iterations so that the last round applied is always round 11 (the tail of
// p12), then presents the result until it is taken.
//
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : ascon_perm_sequencer_if.slave (request, result, busy, debug)
//
// Parameters:
//   HW_PERMUTATION_N : rounds per clock, one of 2, 3, 4, 6, 12
//   CLK_FACTOR       : 12 / HW_PERMUTATION_N, at most 7
// ---------------------------------------------------------------------------

// Combinational slice: applies HW_PERMUTATION_N consecutive rounds starting
// at absolute round number round_index_i * HW_PERMUTATION_N.
module ascon_permutation_n #(
    parameter int HW_PERMUTATION_N = 6
) (
    input  logic [319:0] state_i,
    input  logic [2:0]   round_index_i,
    output logic [319:0] state_o
);

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // One Ascon round: constant addition, bitsliced S-box, linear layer.
    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] rnd);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128];
        x3 = s[127:64];
        x4 = s[63:0];
        // Round constant for round r is {15-r, r}.
        x2 = x2 ^ {56'd0, (4'd15 - rnd), rnd};
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
        x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic logic [319:0] apply_rounds(input logic [319:0] s, input logic [2:0] idx);
        logic [319:0] acc;
        acc = s;
        for (int r = 0; r < HW_PERMUTATION_N; r++) begin
            acc = ascon_round(acc, 4'(int'(idx) * HW_PERMUTATION_N + r));
        end
        return acc;
    endfunction

    always_comb begin
        state_o = apply_rounds(state_i, round_index_i);
    end

endmodule

module ascon_perm_sequencer #(
    parameter int HW_PERMUTATION_N = 6,
    parameter int CLK_FACTOR       = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    ascon_perm_sequencer_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] N_W  = 4'(HW_PERMUTATION_N);
    localparam logic [2:0] CF_W = 3'(CLK_FACTOR);

    // Elaboration-time parameter checks.
    if (!(HW_PERMUTATION_N == 2 || HW_PERMUTATION_N == 3 || HW_PERMUTATION_N == 4 ||
          HW_PERMUTATION_N == 6 || HW_PERMUTATION_N == 12)) begin : g_bad_n
        $error("HW_PERMUTATION_N must be one of 2, 3, 4, 6, 12");
    end
    if (CLK_FACTOR * HW_PERMUTATION_N != 12 || CLK_FACTOR > 7) begin : g_bad_cf
        $error("CLK_FACTOR must equal 12 / HW_PERMUTATION_N and be at most 7");
    end

    logic [1:0]   fsm_q, fsm_d;
    logic [319:0] state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [2:0]   idx_q, idx_d;
    logic         err_q, err_d;
    logic         done_valid_q, done_valid_d;

    logic [319:0] slice_out;
    logic         start_fire;
    logic         done_fire;
    logic         req_legal;
    logic [3:0]   req_cycles;

    ascon_permutation_n #(
        .HW_PERMUTATION_N(HW_PERMUTATION_N)
    ) u_slice (
        .state_i      (state_q),
        .round_index_i(idx_q),
        .state_o      (slice_out)
    );

    assign start_fire = bus.start_valid_i & (fsm_q == ST_IDLE);
    assign done_fire  = done_valid_q & bus.done_ready_i;

    assign req_legal  = ((bus.rounds_i == 4'd6) || (bus.rounds_i == 4'd8) ||
                         (bus.rounds_i == 4'd12)) && ((bus.rounds_i % N_W) == 4'd0);
    assign req_cycles = bus.rounds_i / N_W;

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        err_d   = err_q;
        case (fsm_q)
            ST_IDLE: begin
                if (start_fire) begin
                    state_d = bus.state_i;
                    if (req_legal) begin
                        cnt_d = req_cycles;
                        // Start late enough that the final iteration covers round 11.
                        idx_d = CF_W - req_cycles[2:0];
                        fsm_d = ST_RUN;
                    end else begin
                        err_d = 1'b1;
                        fsm_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                state_d = slice_out;
                idx_d   = idx_q + 3'd1;
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    fsm_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (done_fire) begin
                    err_d = 1'b0;
                    fsm_d = ST_IDLE;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    // done_valid trails entry into DONE by one clock so the result channel is
    // driven purely from flops; it drops on the same edge that leaves DONE.
    always_comb begin
        done_valid_d = (fsm_q == ST_DONE) & ~done_fire;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q        <= ST_IDLE;
            state_q      <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            err_q        <= 1'b0;
            done_valid_q <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            err_q        <= err_d;
            done_valid_q <= done_valid_d;
        end
    end

    assign bus.start_ready_o = (fsm_q == ST_IDLE);
    assign bus.done_valid_o  = done_valid_q;
    assign bus.state_o       = state_q;
    assign bus.error_o       = err_q;
    assign bus.busy_o        = (fsm_q == ST_RUN);
    assign bus.fsm_dbg_o     = fsm_q;

endmodule

// File: tb/tb_ascon_perm_sequencer.sv
module tb_ascon_perm_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ascon_perm_sequencer_if bus6();
    ascon_perm_sequencer_if bus4();

    logic         sv;
    logic         dr;
    logic [319:0] st_in;
    logic [3:0]   rnd_in;
    logic         sel4;

    assign bus6.start_valid_i = sv & ~sel4;
    assign bus4.start_valid_i = sv & sel4;
    assign bus6.state_i       = st_in;
    assign bus4.state_i       = st_in;
    assign bus6.rounds_i      = rnd_in;
    assign bus4.rounds_i      = rnd_in;
    assign bus6.done_ready_i  = dr & ~sel4;
    assign bus4.done_ready_i  = dr & sel4;

    logic         o_start_ready, o_done_valid, o_error, o_busy;
    logic [319:0] o_state;
    assign o_start_ready = sel4 ? bus4.start_ready_o : bus6.start_ready_o;
    assign o_done_valid  = sel4 ? bus4.done_valid_o  : bus6.done_valid_o;
    assign o_error       = sel4 ? bus4.error_o       : bus6.error_o;
    assign o_busy        = sel4 ? bus4.busy_o        : bus6.busy_o;
    assign o_state       = sel4 ? bus4.state_o       : bus6.state_o;

    ascon_perm_sequencer #(.HW_PERMUTATION_N(6), .CLK_FACTOR(2)) u_dut6 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus6.slave)
    );

    ascon_perm_sequencer #(.HW_PERMUTATION_N(4), .CLK_FACTOR(3)) u_dut4 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus4.slave)
    );

    // ---------------- reference model ----------------
    logic [4:0] sbox_tab [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    logic [7:0] rc_tab [12] = '{
        8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

    function automatic logic [63:0] rot(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Ascon p^rounds: rounds 12-rounds .. 11, S-box applied column by column.
    function automatic logic [319:0] ref_perm(input logic [319:0] s, input int rounds);
        logic [63:0] x [5];
        logic [4:0]  v, o;
        for (int k = 0; k < 5; k++) x[k] = s[319 - 64*k -: 64];
        for (int r = 12 - rounds; r < 12; r++) begin
            x[2] = x[2] ^ {56'd0, rc_tab[r]};
            for (int j = 0; j < 64; j++) begin
                v = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
                o = sbox_tab[v];
                x[0][j] = o[4]; x[1][j] = o[3]; x[2][j] = o[2]; x[3][j] = o[1]; x[4][j] = o[0];
            end
            x[0] = x[0] ^ rot(x[0], 19) ^ rot(x[0], 28);
            x[1] = x[1] ^ rot(x[1], 61) ^ rot(x[1], 39);
            x[2] = x[2] ^ rot(x[2], 1)  ^ rot(x[2], 6);
            x[3] = x[3] ^ rot(x[3], 10) ^ rot(x[3], 17);
            x[4] = x[4] ^ rot(x[4], 7)  ^ rot(x[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] r;
        for (int k = 0; k < 10; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_mis = 0;
    logic [319:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Handshake monitor.
    logic count_en = 1'b0;
    int   n_start = 0;
    int   n_done  = 0;
    always @(posedge clk) begin
        if (count_en) begin
            n_start <= n_start + ((bus6.start_valid_i && bus6.start_ready_o) ? 1 : 0)
                               + ((bus4.start_valid_i && bus4.start_ready_o) ? 1 : 0);
            n_done  <= n_done  + ((bus6.done_valid_o && bus6.done_ready_i) ? 1 : 0)
                               + ((bus4.done_valid_o && bus4.done_ready_i) ? 1 : 0);
        end
    end

    // ---------------- driver ----------------
    // Issues one request on the selected DUT, holds the result for `hold`
    // cycles of backpressure, then takes it. Called at posedge+1.
    task automatic run_job(input logic [319:0] st, input int rounds, input int hold,
                           input bit pulse_start);
        int n, lat, busy_cnt, waits, exp_lat, exp_busy;
        bit legal;
        logic [319:0] exp_st, got_st;
        logic got_err;
        n = sel4 ? 4 : 6;
        legal = (rounds == 6 || rounds == 8 || rounds == 12) && (rounds % n == 0);
        exp_q.push_back(legal ? ref_perm(st, rounds) : st);
        exp_lat  = legal ? rounds / n + 1 : 1;
        exp_busy = legal ? rounds / n : 0;

        waits = 0;
        while (!o_start_ready && waits < 20) begin
            @(posedge clk); #1; waits++;
        end
        check_eq("start_ready", o_start_ready, 1);
        sv = 1'b1; st_in = st; rnd_in = 4'(rounds);
        @(posedge clk); #1;
        sv = 1'b0; st_in = rand320(); rnd_in = 4'($urandom_range(0, 15));
        busy_cnt = o_busy ? 1 : 0;
        lat = 0;
        while (!o_done_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
            busy_cnt += o_busy ? 1 : 0;
        end
        check_eq("latency", lat, exp_lat);
        check_eq("busy_cycles", busy_cnt, exp_busy);
        exp_st = exp_q.pop_front();
        check_eq("state", o_state, exp_st);
        check_eq("error", o_error, !legal);
        got_st = o_state; got_err = o_error;

        for (int h = 0; h < hold; h++) begin
            dr = 1'b0;
            sv = pulse_start ? 1'($urandom_range(0, 1)) : 1'b0;
            st_in = rand320();
            @(posedge clk); #1;
            check_eq("hold_valid", o_done_valid, 1);
            check_eq("hold_state", o_state, got_st);
            check_eq("hold_error", o_error, got_err);
            check_eq("hold_no_ready", o_start_ready, 0);
        end
        sv = pulse_start;
        dr = 1'b1;
        @(posedge clk); #1;
        dr = 1'b0; sv = 1'b0;
        check_eq("idle_after_done", o_start_ready, 1);
        check_eq("valid_drop", o_done_valid, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [319:0] iv_state;
        int rounds;
        bit stray_done;
        rst_n = 1'b0; sv = 1'b0; dr = 1'b0; sel4 = 1'b0;
        st_in = '0; rnd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready6", bus6.start_ready_o, 1);
        check_eq("rst_valid6", bus6.done_valid_o, 0);
        check_eq("rst_busy6", bus6.busy_o, 0);
        check_eq("rst_error6", bus6.error_o, 0);
        check_eq("rst_state6", bus6.state_o, 0);
        check_eq("rst_ready4", bus4.start_ready_o, 1);
        check_eq("rst_valid4", bus4.done_valid_o, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Ascon-128 initialisation state IV || K || N.
        iv_state = {64'h80400c0600000000, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h000102030405060708090a0b0c0d0e0f};
        run_job(iv_state, 12, 0, 0);
        run_job(rand320(), 6, 0, 0);
        run_job(rand320(), 8, 0, 0);      // not a multiple of 6: rejected
        run_job(rand320(), 5, 0, 0);      // not a legal round count
        run_job(rand320(), 0, 1, 0);
        run_job(rand320(), 12, 5, 1);     // backpressure with stray starts

        sel4 = 1'b1;
        @(posedge clk); #1;
        run_job(rand320(), 8, 0, 0);
        run_job(rand320(), 12, 2, 1);
        run_job(rand320(), 6, 0, 0);      // not a multiple of 4: rejected
        sel4 = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a p12 run.
        sv = 1'b1; st_in = rand320(); rnd_in = 4'd12;
        @(posedge clk); #1;
        sv = 1'b0;
        @(posedge clk); #3;
        check_eq("pre_rst_busy", o_busy, 1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_state", o_state, 0);
        check_eq("arst_busy", o_busy, 0);
        check_eq("arst_valid", o_done_valid, 0);
        check_eq("arst_error", o_error, 0);
        check_eq("arst_ready", o_start_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        stray_done = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (o_done_valid) stray_done = 1'b1;
        end
        check_eq("no_stray_done", stray_done, 0);
        check_eq("ready_after_rst", o_start_ready, 1);
        run_job(rand320(), 12, 0, 0);

        // Random legal traffic on both sequencers.
        count_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            sel4 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) rounds = 12;
            else rounds = sel4 ? 8 : 6;
            run_job(rand320(), rounds, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        @(posedge clk); #1;
        count_en = 1'b0;
        check_eq("start_count", n_start, 1000);
        check_eq("done_eq_start", n_done, n_start);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
